// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle between a requesting controller
// (master) and the bit-serial adder sequencer (slave).
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell stepped LSB first over
// two WIDTH-bit operands, one bit per clock.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; last result held on sum/cout
// RUN    | one operand bit consumed per clock, busy high
// DONE   | single-cycle done pulse; start here chains straight into RUN
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_c;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] s_msb;
    logic [WIDTH-1:0] sum_next;

    // Full-adder cell from two half adders, plus the shifted partial sum.
    always_comb begin
        ha1_s  = a_sh[0] ^ b_sh[0];
        ha1_c  = a_sh[0] & b_sh[0];
        s_bit  = ha1_s ^ carry;
        ha2_c  = ha1_s & carry;
        c_next = ha1_c | ha2_c;
        s_msb  = '0;
        s_msb[WIDTH-1] = s_bit;
        sum_next = (sum_sh >> 1) | s_msb;
    end

    // Sequencer, operand/sum shifters, carry, bit counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= c_next;
                    if (cnt == CNT_LAST) begin
                        state  <= S_DONE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        sum_q  <= sum_next;
                        cout_q <= c_next;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // IDLE and DONE accept identically; an unused encoding
                // behaves as IDLE so the machine always recovers.
                default: begin
                    if (bus.start) begin
                        state  <= S_RUN;
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        sum_sh <= '0;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH 1, 8 and 32.
// Expected results come from plain integer addition a+b+cin.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(1))  if1 ();
    serial_adder_ctrl_if #(.WIDTH(8))  if8 ();
    serial_adder_ctrl_if #(.WIDTH(32)) if32 ();

    serial_adder_ctrl #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_adder_ctrl #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder_ctrl #(.WIDTH(32)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        case (w)
            1: begin if1.start = s; if1.a = a[0]; if1.b = b[0]; if1.cin = c; end
            8: begin if8.start = s; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = c; end
            default: begin if32.start = s; if32.a = a; if32.b = b; if32.cin = c; end
        endcase
    endtask

    // {busy, done, cout, sum zero-extended to 32}
    function automatic logic [34:0] f_obs(input int w);
        case (w)
            1:       return {if1.busy, if1.done, if1.cout, 31'd0, if1.sum};
            8:       return {if8.busy, if8.done, if8.cout, 24'd0, if8.sum};
            default: return {if32.busy, if32.done, if32.cout, if32.sum};
        endcase
    endfunction

    // One operation, entered and left on a falling edge.
    // mode 0: start dropped in RUN; 1: start held high with changing operands;
    // 2: start and operands toggled randomly during RUN.
    // chain=1 leaves start for the caller so the next op is accepted in DONE.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input int mode, input logic chain, input string tag);
        longint unsigned mask, t;
        logic [31:0] prev_sum, exp_sum;
        logic        prev_cout, exp_cout, seen;
        logic [34:0] o;
        int          edges;
        mask     = (64'd1 << w) - 64'd1;
        t        = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
        exp_sum  = 32'(t & mask);
        exp_cout = 1'((t >> w) & 64'd1);
        o = f_obs(w);
        prev_sum  = o[31:0];
        prev_cout = o[32];
        drive(w, 1'b1, a, b, c);
        @(posedge clk); #1;
        o = f_obs(w);
        check({tag, "/accept_busy"}, 64'(o[34]), 64'd1);
        check({tag, "/accept_done"}, 64'(o[33]), 64'd0);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < w + 4) begin
            @(negedge clk);
            case (mode)
                0:       drive(w, 1'b0, a, b, c);
                1:       drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
                default: drive(w, 1'($urandom), $urandom, $urandom, 1'($urandom));
            endcase
            @(posedge clk); #1;
            edges++;
            o = f_obs(w);
            check({tag, "/busy_done_overlap"}, 64'(o[34] & o[33]), 64'd0);
            if (o[33]) begin
                seen = 1'b1;
            end else begin
                check({tag, "/run_busy"}, 64'(o[34]), 64'd1);
                check({tag, "/held"}, {31'd0, o[32:0]}, {31'd0, prev_cout, prev_sum});
            end
        end
        check({tag, "/latency"}, 64'(edges), 64'(w));
        check({tag, "/sum"}, 64'(o[31:0]), 64'(exp_sum));
        check({tag, "/cout"}, 64'(o[32]), 64'(exp_cout));
        @(negedge clk);
        if (!chain) begin
            drive(w, 1'b0, a, b, c);
            @(posedge clk); #1;
            o = f_obs(w);
            check({tag, "/idle_flags"}, 64'(o[34:33]), 64'd0);
            check({tag, "/idle_held"}, 64'(o[32:0]), {31'd0, exp_cout, exp_sum});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [34:0] o;
        int          done_seen;
        int          widths[3];
        widths = '{1, 8, 32};
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        check("reset_w1", 64'(f_obs(1)), 64'd0);
        check("reset_w8", 64'(f_obs(8)), 64'd0);
        check("reset_w32", 64'(f_obs(32)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(8, 32'h5A, 32'h3C, 1'b0, 0, 1'b0, "w8_5a_3c");
        op(8, 32'hFF, 32'h01, 1'b0, 0, 1'b0, "w8_ff_01");
        op(8, 32'hFF, 32'hFF, 1'b1, 0, 1'b0, "w8_ff_ff_c1");
        op(8, 32'h01, 32'h01, 1'b0, 1, 1'b1, "w8_chain_01");
        op(8, 32'h80, 32'h80, 1'b0, 1, 1'b0, "w8_chain_80");
        op(8, 32'hC3, 32'h5E, 1'b1, 2, 1'b0, "w8_toggle");

        // Async reset in the 4th RUN cycle.
        drive(8, 1'b1, 32'h33, 32'h44, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 32'h33, 32'h44, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_run", 64'(f_obs(8)), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            o = f_obs(8);
            if (o[33] || o[34]) done_seen++;
        end
        check("rst_no_done", 64'(done_seen), 64'd0);
        @(negedge clk);
        op(8, 32'h10, 32'h20, 1'b0, 0, 1'b0, "w8_after_rst");

        op(1, 32'h1, 32'h1, 1'b1, 0, 1'b0, "w1_111");

        foreach (widths[k]) begin
            for (int i = 0; i < 12; i++) begin
                op(widths[k], $urandom, $urandom, 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom), $sformatf("rand_w%0d_%0d", widths[k], i));
            end
            drive(widths[k], 1'b0, 32'd0, 32'd0, 1'b0);
            repeat (2) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
